// File: rtl/draw_image_if.sv
// ROM bus between the image compositor and the image ROM. The compositor
// issues a registered address; the ROM returns the colour one cycle later.
interface draw_image_if;
  logic [11:0] pixel_addr;
  logic [11:0] rgb_pixel;

  modport master (output pixel_addr, input rgb_pixel);
  modport slave  (input pixel_addr, output rgb_pixel);
endinterface

// File: rtl/draw_image.sv
// Overlays an IMG_W x IMG_H image from a synchronous ROM onto a VGA stream.
// Three-stage pipeline: address/in-box, ROM wait, colour mux. The image
// position and enable are sampled once per frame on the vblank rising edge
// so mid-frame changes never tear the current frame.
module draw_image #(
  parameter int unsigned IMG_W   = 64,
  parameter int unsigned IMG_H   = 64,
  parameter logic [11:0] KEY_RGB = 12'hF0F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [10:0]  hcount_in,
  input  logic [10:0]  vcount_in,
  input  logic         hsync_in,
  input  logic         vsync_in,
  input  logic         hblnk_in,
  input  logic         vblnk_in,
  input  logic [11:0]  rgb_in,
  input  logic [11:0]  xpos,
  input  logic [11:0]  ypos,
  input  logic         en,
  draw_image_if.master rom,
  output logic [10:0]  hcount_out,
  output logic [10:0]  vcount_out,
  output logic         hsync_out,
  output logic         vsync_out,
  output logic         hblnk_out,
  output logic         vblnk_out,
  output logic [11:0]  rgb_out
);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } timing_t;

  localparam logic [12:0] IMG_W13 = 13'(IMG_W);
  localparam logic [12:0] IMG_H13 = 13'(IMG_H);

  // Frame-latched placement
  logic [11:0] xpos_q, ypos_q;
  logic        en_q;
  logic        vblnk_prev_q;

  // Pipeline registers
  timing_t     t1_q, t2_q, t3_q;
  logic        in_box_s1_q, in_box_s2_q;
  logic [11:0] pixel_addr_q;
  logic [11:0] rgb_out_q;

  // Next-state values
  timing_t     t0_d;
  logic        in_box_d;
  logic [11:0] pixel_addr_d;
  logic [11:0] rgb_out_d;

  // 13-bit comparison operands so xpos_q + IMG_W can never wrap
  logic [12:0] h13_s, v13_s, x13_s, y13_s, xend_s, yend_s;
  logic [5:0]  dx_s, dy_s;

  // Stage-1 decision: is the incoming pixel inside the latched image box
  always_comb begin
    t0_d   = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
               vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
    h13_s  = {2'b00, hcount_in};
    v13_s  = {2'b00, vcount_in};
    x13_s  = {1'b0, xpos_q};
    y13_s  = {1'b0, ypos_q};
    xend_s = x13_s + IMG_W13;
    yend_s = y13_s + IMG_H13;
    // Low six bits of the difference depend only on the low six operand bits
    dx_s   = hcount_in[5:0] - xpos_q[5:0];
    dy_s   = vcount_in[5:0] - ypos_q[5:0];
    in_box_d = en_q && !hblnk_in && !vblnk_in &&
               (h13_s >= x13_s) && (h13_s < xend_s) &&
               (v13_s >= y13_s) && (v13_s < yend_s);
    if (in_box_d) begin
      pixel_addr_d = {dy_s, dx_s};
    end else begin
      pixel_addr_d = 12'h000;
    end
  end

  // Stage-3 colour choice: ROM pixel unless outside the box or transparent
  always_comb begin
    if (in_box_s2_q && (rom.rgb_pixel != KEY_RGB)) begin
      rgb_out_d = rom.rgb_pixel;
    end else begin
      rgb_out_d = t2_q.rgb;
    end
  end

  // Sample placement and enable on the vblank rising edge only
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_q       <= 12'h000;
      ypos_q       <= 12'h000;
      en_q         <= 1'b0;
      vblnk_prev_q <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      if (vblnk_in && !vblnk_prev_q) begin
        xpos_q <= xpos;
        ypos_q <= ypos;
        en_q   <= en;
      end
    end
  end

  // Three-stage pipeline: address, ROM wait, composited output
  always_ff @(posedge clk) begin
    if (rst) begin
      t1_q         <= '0;
      t2_q         <= '0;
      t3_q         <= '0;
      in_box_s1_q  <= 1'b0;
      in_box_s2_q  <= 1'b0;
      pixel_addr_q <= 12'h000;
      rgb_out_q    <= 12'h000;
    end else begin
      t1_q         <= t0_d;
      in_box_s1_q  <= in_box_d;
      pixel_addr_q <= pixel_addr_d;
      t2_q         <= t1_q;
      in_box_s2_q  <= in_box_s1_q;
      t3_q         <= t2_q;
      rgb_out_q    <= rgb_out_d;
    end
  end

  assign rom.pixel_addr = pixel_addr_q;
  assign hcount_out     = t3_q.hcount;
  assign vcount_out     = t3_q.vcount;
  assign hsync_out      = t3_q.hsync;
  assign vsync_out      = t3_q.vsync;
  assign hblnk_out      = t3_q.hblnk;
  assign vblnk_out      = t3_q.vblnk;
  assign rgb_out        = rgb_out_q;

endmodule

// File: tb/tb_draw_image.sv
// Randomised bench for draw_image with a frame-level reference model and a
// synchronous ROM model.
module tb_draw_image;
  localparam int          IMG_W = 64;
  localparam int          IMG_H = 64;
  localparam logic [11:0] KEY   = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = 11'd0, vcount_in = 11'd0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = 12'h000, xpos = 12'h000, ypos = 12'h000;
  logic        en = 1'b0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_image_if rom_bus ();

  draw_image #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KEY_RGB(KEY)) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .en(en),
    .rom(rom_bus),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Image content: origin transparent, row 0 plain 0A5, row 7 transparent
  function automatic logic [11:0] rom_f(input logic [11:0] a);
    if (a == 12'h000 || a[11:6] == 6'd7) return KEY;
    if (a[11:6] == 6'd0) return 12'h0A5;
    return 12'h0A5 ^ {a[5:0], a[11:6]};
  endfunction

  always @(posedge clk) rom_bus.rgb_pixel <= rom_f(rom_bus.pixel_addr);

  typedef struct packed {
    logic [10:0] hc, vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic [11:0] addr;
  } rec_t;

  rec_t hist[$];
  int   m_x = 0, m_y = 0;
  bit   m_en = 1'b0, m_prev_vb = 1'b0;
  int   checks = 0, errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: predict from current inputs, advance, then compare
  task automatic step();
    rec_t r;
    int hc, vc;
    bit inb;
    logic [11:0] px;
    r = '0;
    if (!rst) begin
      hc = int'(hcount_in);
      vc = int'(vcount_in);
      inb = m_en && !hblnk_in && !vblnk_in &&
            hc >= m_x && hc < m_x + IMG_W && vc >= m_y && vc < m_y + IMG_H;
      r.hc = hcount_in; r.vc = vcount_in;
      r.hs = hsync_in;  r.vs = vsync_in;
      r.hb = hblnk_in;  r.vb = vblnk_in;
      r.rgb = rgb_in;
      if (inb) begin
        r.addr = 12'((vc - m_y) * 64 + (hc - m_x));
        px = rom_f(r.addr);
        if (px != KEY) r.rgb = px;
      end
    end
    @(posedge clk);
    if (rst) begin
      m_x = 0; m_y = 0; m_en = 1'b0; m_prev_vb = 1'b0;
      foreach (hist[i]) hist[i] = '0;
    end else begin
      if (vblnk_in && !m_prev_vb) begin
        m_x = int'(xpos); m_y = int'(ypos); m_en = en;
      end
      m_prev_vb = vblnk_in;
    end
    hist.push_back(r);
    void'(hist.pop_front());
    #1;
    check_eq("pixel_addr", 32'(rom_bus.pixel_addr), 32'(hist[2].addr));
    check_eq("hcount_out", 32'(hcount_out), 32'(hist[0].hc));
    check_eq("vcount_out", 32'(vcount_out), 32'(hist[0].vc));
    check_eq("hsync_out",  32'(hsync_out),  32'(hist[0].hs));
    check_eq("vsync_out",  32'(vsync_out),  32'(hist[0].vs));
    check_eq("hblnk_out",  32'(hblnk_out),  32'(hist[0].hb));
    check_eq("vblnk_out",  32'(vblnk_out),  32'(hist[0].vb));
    check_eq("rgb_out",    32'(rgb_out),    32'(hist[0].rgb));
  endtask

  task automatic set_pix(input int h, input int v, input logic [11:0] c);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hblnk_in = 1'b0; vblnk_in = 1'b0;
    hsync_in = 1'($urandom_range(1, 0)); vsync_in = 1'($urandom_range(1, 0));
    rgb_in = c;
  endtask

  task automatic pix(input int h, input int v, input logic [11:0] c);
    set_pix(h, v, c);
    step();
  endtask

  // Blanking interval with a vblank rise presenting a new placement
  task automatic latch(input int x, input int y, input logic e);
    xpos = 12'(x); ypos = 12'(y); en = e;
    hcount_in = 11'd0; vcount_in = 11'd0; rgb_in = 12'h000;
    hblnk_in = 1'b1; vblnk_in = 1'b1;
    step();
    step();
    hblnk_in = 1'b0; vblnk_in = 1'b0;
    step();
  endtask

  initial begin
    repeat (3) hist.push_back('0);
    xpos = 12'd100; ypos = 12'd50; en = 1'b1;
    repeat (3) step();
    check_eq("reset_rgb", 32'(rgb_out), 32'h0);
    check_eq("reset_addr", 32'(rom_bus.pixel_addr), 32'h0);
    rst = 1'b0;

    // First frame after reset: en not yet latched, nothing drawn
    pix(100, 50, 12'h123);
    check_eq("no_latch_addr", 32'(rom_bus.pixel_addr), 32'h0);
    pix(110, 60, 12'h321);
    repeat (3) pix(0, 0, 12'h000);

    // Latency of a 2-cycle hsync pulse
    set_pix(5, 5, 12'h000); hsync_in = 1'b0; step();
    hsync_in = 1'b1; step();
    step();
    check_eq("lat_hs_early", 32'(hsync_out), 32'h0);
    hsync_in = 1'b0; step();
    check_eq("lat_hs_rise", 32'(hsync_out), 32'h1);
    step();
    check_eq("lat_hs_hold", 32'(hsync_out), 32'h1);
    step();
    check_eq("lat_hs_fall", 32'(hsync_out), 32'h0);

    // Addressing and transparency
    latch(100, 50, 1'b1);
    pix(100, 50, 12'h123);
    check_eq("addr_origin", 32'(rom_bus.pixel_addr), 32'h000);
    pix(101, 50, 12'h123);
    check_eq("addr_101_50", 32'(rom_bus.pixel_addr), 32'h001);
    pix(163, 113, 12'h123);
    check_eq("rgb_origin_key", 32'(rgb_out), 32'h123);
    check_eq("addr_corner", 32'(rom_bus.pixel_addr), 32'hFFF);
    pix(164, 50, 12'h123);
    check_eq("rgb_101_50", 32'(rgb_out), 32'h0A5);
    check_eq("addr_outside", 32'(rom_bus.pixel_addr), 32'h000);
    repeat (3) pix(0, 0, 12'h000);

    // Frame coherence: new xpos only takes effect after the next vblank rise
    xpos = 12'd200;
    pix(100, 50, 12'h456);
    check_eq("coh_old_pos", 32'(rom_bus.pixel_addr), 32'h000);
    pix(200, 51, 12'h456);
    check_eq("coh_new_ignored", 32'(rom_bus.pixel_addr), 32'h000);
    latch(200, 50, 1'b1);
    pix(201, 51, 12'h456);
    check_eq("coh_new_pos", 32'(rom_bus.pixel_addr), 32'h041);
    pix(101, 51, 12'h456);
    check_eq("coh_old_gone", 32'(rom_bus.pixel_addr), 32'h000);

    // Clipping at the right edge, no wrap to column 0
    latch(1000, 10, 1'b1);
    pix(1000, 20, 12'h111);
    check_eq("clip_left", 32'(rom_bus.pixel_addr), 32'h280);
    pix(1023, 20, 12'h111);
    check_eq("clip_right", 32'(rom_bus.pixel_addr), 32'h297);
    for (int h = 0; h < 6; h++) pix(h, 20, 12'h111);
    check_eq("clip_nowrap", 32'(rom_bus.pixel_addr), 32'h000);
    for (int h = 795; h < 800; h++) pix(h, 20, 12'h222);

    // Reset mid-image
    latch(100, 50, 1'b1);
    pix(110, 55, 12'h333);
    pix(111, 55, 12'h333);
    set_pix(112, 55, 12'h333); rst = 1'b1; step(); rst = 1'b0;
    check_eq("rst_mid_rgb", 32'(rgb_out), 32'h0);
    check_eq("rst_mid_hc", 32'(hcount_out), 32'h0);
    check_eq("rst_mid_addr", 32'(rom_bus.pixel_addr), 32'h0);
    pix(113, 55, 12'h333);
    check_eq("rst_no_draw", 32'(rom_bus.pixel_addr), 32'h0);
    repeat (4) pix(114, 56, 12'h333);

    // Randomised frames, placement and timing
    for (int i = 0; i < 1500; i++) begin
      int r, h, v;
      r = int'($urandom_range(99, 0));
      if (r < 4) begin
        latch(int'($urandom_range(1100, 0)), int'($urandom_range(700, 0)),
              1'($urandom_range(3, 0) != 0));
      end else if (r == 4) begin
        rst = 1'b1; step(); rst = 1'b0;
      end else if (r == 5) begin
        // vblank rise on a pixel that sits inside the box
        set_pix(m_x + 3, m_y + 3, 12'($urandom));
        xpos = 12'($urandom_range(1100, 0)); ypos = 12'($urandom_range(700, 0));
        en = 1'($urandom_range(1, 0));
        vblnk_in = 1'b1;
        step();
        vblnk_in = 1'b0;
      end else begin
        h = m_x + int'($urandom_range(80, 0)) - 8;
        v = m_y + int'($urandom_range(80, 0)) - 8;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
        set_pix(h, v, 12'($urandom));
        hblnk_in = ($urandom_range(9, 0) == 0);
        xpos = 12'($urandom); ypos = 12'($urandom); en = 1'($urandom_range(1, 0));
        step();
      end
    end
    repeat (3) pix(0, 0, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
